// File: rtl/rst_seq_multi.sv
// Reset sequencer: qualifies PLL lock and board reset, then releases NUM_CH domain resets in order.
// Latency: SYNC_STAGES to see an input, STRETCH_CYCLES+1 to first release, STEP_CYCLES per further channel.
// Backpressure: none; reset requests and lock loss always take effect on the next edge.
module rst_seq_multi #(
  parameter int NUM_CH         = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int STEP_CYCLES    = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk_sys,
  input  logic              rst_sys,
  input  logic              pll_locked_i,
  input  logic              ext_rst_ni,
  input  logic              sw_rst_req_i,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              all_rel_o,
  output logic [7:0]        lock_lost_cnt_o
);

  // One counter serves both the stretch window and the inter-channel spacing.
  localparam int CNT_MAX = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CH - 1);

  // Parameter sanity, caught at elaboration.
  if (NUM_CH < 1) begin : g_chk_num_ch
    $error("rst_seq_multi: NUM_CH must be >= 1");
  end
  if (STRETCH_CYCLES < 1) begin : g_chk_stretch
    $error("rst_seq_multi: STRETCH_CYCLES must be >= 1");
  end
  if (STEP_CYCLES < 1) begin : g_chk_step
    $error("rst_seq_multi: STEP_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("rst_seq_multi: SYNC_STAGES must be >= 2");
  end

  typedef enum logic [1:0] {
    WAIT_OK = 2'd0,
    STRETCH = 2'd1,
    SEQ     = 2'd2,
    RUN     = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic                   locked_s;
  logic                   ext_s;
  logic                   ok;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_inc;

  // Bring the asynchronous lock and button inputs into clk_sys; rst_sys clears them too.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      lock_sync <= '0;
      ext_sync  <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
      ext_sync  <= {ext_sync[SYNC_STAGES-2:0], ext_rst_ni};
    end
  end

  assign locked_s = lock_sync[SYNC_STAGES-1];
  assign ext_s    = ext_sync[SYNC_STAGES-1];
  assign ok       = locked_s & ext_s;
  assign idx_inc  = idx + IDX_W'(1);

  // Sequencer FSM; every output is a flop so domain resets never glitch.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state           <= WAIT_OK;
      cnt             <= '0;
      idx             <= '0;
      rst_n_o         <= '0;
      all_rel_o       <= 1'b0;
      lock_lost_cnt_o <= '0;
    end else begin
      case (state)
        WAIT_OK: begin
          rst_n_o   <= '0;
          all_rel_o <= 1'b0;
          cnt       <= '0;
          idx       <= '0;
          if (ok) begin
            state <= STRETCH;
          end
        end

        STRETCH: begin
          if (!ok) begin
            state <= WAIT_OK;
            cnt   <= '0;
          end else if (sw_rst_req_i) begin
            // A software request restarts the qualification window.
            cnt <= '0;
          end else if (cnt == STRETCH_LAST) begin
            cnt     <= '0;
            idx     <= '0;
            rst_n_o <= NUM_CH'(1);
            if (NUM_CH == 1) begin
              state     <= RUN;
              all_rel_o <= 1'b1;
            end else begin
              state <= SEQ;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        SEQ, RUN: begin
          if (!ok) begin
            // Lock loss or board reset: drop every domain at once.
            state     <= WAIT_OK;
            cnt       <= '0;
            idx       <= '0;
            rst_n_o   <= '0;
            all_rel_o <= 1'b0;
            if (!locked_s && (lock_lost_cnt_o != 8'hFF)) begin
              lock_lost_cnt_o <= lock_lost_cnt_o + 8'd1;
            end
          end else if (sw_rst_req_i) begin
            // Software reset keeps qualification but replays the whole stretch and sequence.
            state     <= STRETCH;
            cnt       <= '0;
            idx       <= '0;
            rst_n_o   <= '0;
            all_rel_o <= 1'b0;
          end else if (state == SEQ) begin
            if (cnt == STEP_LAST) begin
              // Released bits form a thermometer code, so shifting in a 1 releases the next channel.
              cnt     <= '0;
              idx     <= idx_inc;
              rst_n_o <= (rst_n_o << 1) | NUM_CH'(1);
              if (idx_inc == LAST_IDX) begin
                state     <= RUN;
                all_rel_o <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            rst_n_o   <= {NUM_CH{1'b1}};
            all_rel_o <= 1'b1;
          end
        end

        default: begin
          state     <= WAIT_OK;
          cnt       <= '0;
          idx       <= '0;
          rst_n_o   <= '0;
          all_rel_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
